// File: rtl/rf_port_ctrl_if.sv
// Bundle of every signal between rf_port_ctrl, its two requesters and the
// three-port register-file RAM. The controller uses the slave view; the
// environment (requesters plus RAM) uses the master view.
//
// Handshake: a requester raises mN_req with mN_re/mN_we and all operands and
// holds them unchanged until mN_gnt is seen high in the same cycle; the
// request is consumed at the clock edge ending that cycle and may change
// right after. mN_gnt never rises while ready is low. Read data is returned
// one cycle after the grant, qualified by mN_rvalid for exactly one cycle.
interface rf_port_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  logic          m0_req;
  logic          m0_re;
  logic          m0_we;
  logic [AW-1:0] m0_ra;
  logic [AW-1:0] m0_rb;
  logic [AW-1:0] m0_wa;
  logic [DW-1:0] m0_wd;
  logic          m0_gnt;
  logic          m0_rvalid;

  logic          m1_req;
  logic          m1_re;
  logic          m1_we;
  logic [AW-1:0] m1_ra;
  logic [AW-1:0] m1_rb;
  logic [AW-1:0] m1_wa;
  logic [DW-1:0] m1_wd;
  logic          m1_gnt;
  logic          m1_rvalid;

  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          ready;

  logic [AW-1:0] ram_addr_a;
  logic [AW-1:0] ram_addr_b;
  logic [AW-1:0] ram_addr_wr;
  logic [DW-1:0] ram_data_in;
  logic          ram_we;
  logic [DW-1:0] ram_data_a;
  logic [DW-1:0] ram_data_b;

  // Controller FSM state for debug and checkers (0 = INIT, 1 = RUN).
  logic          fsm_state;

  modport slave (
    input  m0_req, m0_re, m0_we, m0_ra, m0_rb, m0_wa, m0_wd,
    input  m1_req, m1_re, m1_we, m1_ra, m1_rb, m1_wa, m1_wd,
    input  ram_data_a, ram_data_b,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
    output rdata_a, rdata_b, ready,
    output ram_addr_a, ram_addr_b, ram_addr_wr, ram_data_in, ram_we,
    output fsm_state
  );

  modport master (
    output m0_req, m0_re, m0_we, m0_ra, m0_rb, m0_wa, m0_wd,
    output m1_req, m1_re, m1_we, m1_ra, m1_rb, m1_wa, m1_wd,
    output ram_data_a, ram_data_b,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
    input  rdata_a, rdata_b, ready,
    input  ram_addr_a, ram_addr_b, ram_addr_wr, ram_data_in, ram_we,
    input  fsm_state
  );
endinterface

// File: rtl/rf_port_ctrl.sv
// Two-requester access controller for a 2R1W register-file RAM.
// After reset it sweeps addresses 1..2^AW-1 writing zero, then arbitrates
// the read-port pair and the write port between M0 and M1 with a toggling
// priority pointer. Read data returns one cycle after grant, with same-cycle
// write data forwarded over the RAM's read-first output.
module rf_port_ctrl #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  rf_port_ctrl_if.slave bus
);

  localparam logic [0:0]    ST_INIT   = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW-1:0] FIRST_ADDR = AW'(1);

  logic [0:0]    state;
  logic [AW-1:0] clr_addr;
  logic          prio;
  logic          run;

  // Resource sets: bit 0 = read-port pair, bit 1 = write port.
  logic [1:0]    set0;
  logic [1:0]    set1;
  logic          gnt0;
  logic          gnt1;

  logic          rd_go;
  logic          rd_m1;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          wr_go;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          rv0;
  logic          rv1;
  logic          fwd_a;
  logic          fwd_b;
  logic [DW-1:0] fwd_data;

  // Grants are only possible in RUN and never in a reset cycle, so a write
  // requested while rst is high is never issued.
  assign run = (state == ST_RUN) && !rst;

  // Work out which ports each request needs and arbitrate atomically.
  always_comb begin
    set0 = bus.m0_req ? {bus.m0_we, bus.m0_re} : 2'b00;
    set1 = bus.m1_req ? {bus.m1_we, bus.m1_re} : 2'b00;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run) begin
      if (!prio) begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req && ((set0 & set1) == 2'b00);
      end else begin
        gnt1 = bus.m1_req;
        gnt0 = bus.m0_req && ((set0 & set1) == 2'b00);
      end
    end
  end

  // Route the granted read and write operands; sets are disjoint, so at
  // most one requester owns each port.
  always_comb begin
    rd_go     = 1'b0;
    rd_m1     = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    if (gnt0 && bus.m0_re) begin
      rd_go     = 1'b1;
      rd_addr_a = bus.m0_ra;
      rd_addr_b = bus.m0_rb;
    end else if (gnt1 && bus.m1_re) begin
      rd_go     = 1'b1;
      rd_m1     = 1'b1;
      rd_addr_a = bus.m1_ra;
      rd_addr_b = bus.m1_rb;
    end
    wr_go   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (gnt0 && bus.m0_we) begin
      wr_go   = 1'b1;
      wr_addr = bus.m0_wa;
      wr_data = bus.m0_wd;
    end else if (gnt1 && bus.m1_we) begin
      wr_go   = 1'b1;
      wr_addr = bus.m1_wa;
      wr_data = bus.m1_wd;
    end
  end

  // Drive the RAM: clear sweep in INIT, granted operands in RUN.
  always_comb begin
    bus.ram_addr_a  = rd_addr_a;
    bus.ram_addr_b  = rd_addr_b;
    bus.ram_we      = 1'b0;
    bus.ram_addr_wr = '0;
    bus.ram_data_in = '0;
    if (state == ST_INIT) begin
      bus.ram_we      = !rst;
      bus.ram_addr_wr = clr_addr;
    end else begin
      bus.ram_we      = wr_go;
      bus.ram_addr_wr = wr_addr;
      bus.ram_data_in = wr_data;
    end
  end

  // INIT/RUN sequencing and the clear-sweep address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      clr_addr <= FIRST_ADDR;
    end else if (state == ST_INIT) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == LAST_ADDR) begin
        state <= ST_RUN;
      end
    end
  end

  // Priority pointer flips only when the favoured requester is served.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if ((!prio && gnt0) || (prio && gnt1)) begin
      prio <= ~prio;
    end
  end

  // Read-return tracking and forwarding decisions for the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv0      <= 1'b0;
      rv1      <= 1'b0;
      fwd_a    <= 1'b0;
      fwd_b    <= 1'b0;
      fwd_data <= '0;
    end else begin
      rv0      <= rd_go && !rd_m1;
      rv1      <= rd_go && rd_m1;
      fwd_a    <= rd_go && wr_go && (wr_addr != '0) && (wr_addr == rd_addr_a);
      fwd_b    <= rd_go && wr_go && (wr_addr != '0) && (wr_addr == rd_addr_b);
      fwd_data <= wr_data;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rv0 && !rst;
  assign bus.m1_rvalid = rv1 && !rst;
  assign bus.rdata_a   = fwd_a ? fwd_data : bus.ram_data_a;
  assign bus.rdata_b   = fwd_b ? fwd_data : bus.ram_data_b;
  assign bus.ready     = (state == ST_RUN) && !rst;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_rf_port_ctrl.sv
// Bench for rf_port_ctrl: behavioural RAM, reference model of the access
// rules (priority pointer, port sets, read-after-same-cycle-write value),
// a vector table, hand-written corner sequences and randomized traffic.
`timescale 1ns/1ps
module tb_rf_port_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int RW    = 2 * DW + 2;

  typedef struct packed {
    logic          req;
    logic          re;
    logic          we;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct packed {
    req_t r0;
    req_t r1;
    logic eg0;
    logic eg1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] ram_mem [DEPTH];
  logic          ram_seeded = 1'b0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_p;
  logic [RW-1:0] exp_q[$];

  logic          obs_g0, obs_g1, obs_rv0, obs_rv1;
  logic [DW-1:0] obs_a, obs_b;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  rf_port_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  rf_port_ctrl #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM: registered read-first outputs, address 0 reads 0 and ignores writes.
  // Contents start as garbage so the clear sweep is actually exercised.
  always @(posedge clk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= $urandom;
      ram_seeded <= 1'b1;
    end else if (bus.ram_we && bus.ram_addr_wr != '0) begin
      ram_mem[bus.ram_addr_wr] <= bus.ram_data_in;
    end
    bus.ram_data_a <= (bus.ram_addr_a == '0) ? '0 : ram_mem[bus.ram_addr_a];
    bus.ram_data_b <= (bus.ram_addr_b == '0) ? '0 : ram_mem[bus.ram_addr_b];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic re, input logic we, input int ra, input int rb,
                              input int wa, input logic [DW-1:0] wd);
    req_t r;
    r    = '0;
    r.req = 1'b1;
    r.re = re;
    r.we = we;
    r.ra = AW'(ra);
    r.rb = AW'(rb);
    r.wa = AW'(wa);
    r.wd = wd;
    return r;
  endfunction

  function automatic vec_t mkv(input req_t a, input req_t b, input logic e0, input logic e1);
    vec_t v;
    v.r0  = a;
    v.r1  = b;
    v.eg0 = e0;
    v.eg1 = e1;
    return v;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r     = '0;
    r.req = ($urandom_range(0, 9) < 7);
    r.re  = 1'($urandom_range(0, 1));
    r.we  = 1'($urandom_range(0, 1));
    r.ra  = AW'($urandom_range(0, 15));
    r.rb  = AW'($urandom_range(0, 15));
    r.wa  = AW'($urandom_range(0, 15));
    r.wd  = $urandom;
    return r;
  endfunction

  // Value a read of addr observes, given the write granted the same cycle.
  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] addr, input logic wr,
                                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (addr == '0) return '0;
    if (wr && wa == addr) return wd;
    return ref_mem[addr];
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input req_t r0, input req_t r1);
    bus.m0_req = r0.req; bus.m0_re = r0.re; bus.m0_we = r0.we;
    bus.m0_ra  = r0.ra;  bus.m0_rb = r0.rb; bus.m0_wa = r0.wa; bus.m0_wd = r0.wd;
    bus.m1_req = r1.req; bus.m1_re = r1.re; bus.m1_we = r1.we;
    bus.m1_ra  = r1.ra;  bus.m1_rb = r1.rb; bus.m1_wa = r1.wa; bus.m1_wd = r1.wd;
  endtask

  // One RUN cycle: apply requests, compare against the model, advance model.
  task automatic step(input req_t r0, input req_t r1, output logic g0, output logic g1);
    logic [1:0]    s0, s1;
    logic          e0, e1, rd_any, wr_any;
    req_t          rr, wr;
    logic [RW-1:0] rec;
    drive(r0, r1);
    @(negedge clk);
    s0 = r0.req ? {r0.we, r0.re} : 2'b00;
    s1 = r1.req ? {r1.we, r1.re} : 2'b00;
    if (!ref_p) begin
      e0 = r0.req;
      e1 = r1.req && ((s0 & s1) == 2'b00);
    end else begin
      e1 = r1.req;
      e0 = r0.req && ((s0 & s1) == 2'b00);
    end
    obs_g0  = bus.m0_gnt;
    obs_g1  = bus.m1_gnt;
    obs_rv0 = bus.m0_rvalid;
    obs_rv1 = bus.m1_rvalid;
    obs_a   = bus.rdata_a;
    obs_b   = bus.rdata_b;
    check_bit("ready", bus.ready, 1'b1);
    check_bit("m0_gnt", bus.m0_gnt, e0);
    check_bit("m1_gnt", bus.m1_gnt, e1);
    rec = (exp_q.size() == 0) ? '0 : exp_q.pop_front();
    check_bit("m0_rvalid", bus.m0_rvalid, rec[RW-1]);
    check_bit("m1_rvalid", bus.m1_rvalid, rec[RW-2]);
    if (rec[RW-1] || rec[RW-2]) begin
      check_word("rdata_a", bus.rdata_a, rec[2*DW-1:DW]);
      check_word("rdata_b", bus.rdata_b, rec[DW-1:0]);
    end
    wr_any = (e0 && r0.we) || (e1 && r1.we);
    wr     = (e0 && r0.we) ? r0 : r1;
    rd_any = (e0 && r0.re) || (e1 && r1.re);
    rr     = (e0 && r0.re) ? r0 : r1;
    check_bit("ram_we", bus.ram_we, wr_any);
    if (wr_any) begin
      check_word("ram_addr_wr", DW'(bus.ram_addr_wr), DW'(wr.wa));
      check_word("ram_data_in", bus.ram_data_in, wr.wd);
    end
    if (rd_any) begin
      check_word("ram_addr_a", DW'(bus.ram_addr_a), DW'(rr.ra));
      check_word("ram_addr_b", DW'(bus.ram_addr_b), DW'(rr.rb));
    end
    rec = '0;
    if (rd_any)
      rec = {e0 && r0.re, e1 && r1.re,
             ref_read(rr.ra, wr_any, wr.wa, wr.wd), ref_read(rr.rb, wr_any, wr.wa, wr.wd)};
    exp_q.push_back(rec);
    if (wr_any && wr.wa != '0) ref_mem[wr.wa] = wr.wd;
    if ((!ref_p && e0) || (ref_p && e1)) ref_p = ~ref_p;
    g0 = e0;
    g1 = e1;
    @(posedge clk);
    #1;
  endtask

  // Reset cycle with the given requests held, then the full clear sweep.
  task automatic reset_and_init(input req_t h0, input req_t h1);
    rst = 1'b1;
    drive(h0, h1);
    @(negedge clk);
    check_bit("rst_ready", bus.ready, 1'b0);
    check_bit("rst_m0_gnt", bus.m0_gnt, 1'b0);
    check_bit("rst_m1_gnt", bus.m1_gnt, 1'b0);
    check_bit("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
    check_bit("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
    check_bit("rst_ram_we", bus.ram_we, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk);
      check_bit("init_ready", bus.ready, 1'b0);
      check_bit("init_ram_we", bus.ram_we, 1'b1);
      check_word("init_addr_wr", DW'(bus.ram_addr_wr), DW'(i));
      check_word("init_data_in", bus.ram_data_in, '0);
      check_bit("init_m0_gnt", bus.m0_gnt, 1'b0);
      check_bit("init_m1_gnt", bus.m1_gnt, 1'b0);
      @(posedge clk);
      #1;
    end
    drive('0, '0);
    ref_p = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vt [10];
    req_t idle, cur0, cur1, rd0, rd1, wrm1;
    logic g0, g1, pend0, pend1;
    logic ga [6];

    idle = '0;
    // Expected grants derived by hand from the arbitration rules, p = 0 at start.
    vt[0] = mkv(mk(1, 0, 1, 2, 0, 0), mk(1, 0, 3, 4, 0, 0), 1'b1, 1'b0);
    vt[1] = mkv(mk(1, 0, 1, 2, 0, 0), mk(1, 0, 3, 4, 0, 0), 1'b0, 1'b1);
    vt[2] = mkv(mk(0, 1, 0, 0, 10, 32'hA5A5_0001), mk(1, 0, 10, 11, 0, 0), 1'b1, 1'b1);
    vt[3] = mkv(mk(1, 1, 10, 0, 12, 32'h0000_0C0C), mk(0, 1, 0, 0, 13, 32'h13), 1'b0, 1'b1);
    vt[4] = mkv(mk(1, 1, 10, 0, 12, 32'h0000_0C0C), idle, 1'b1, 1'b0);
    vt[5] = mkv(mk(0, 0, 0, 0, 0, 0), mk(1, 0, 12, 13, 0, 0), 1'b1, 1'b1);
    vt[6] = mkv(mk(1, 0, 2, 3, 0, 0), idle, 1'b1, 1'b0);
    vt[7] = mkv(idle, idle, 1'b0, 1'b0);
    vt[8] = mkv(mk(0, 1, 0, 0, 0, 32'hFFFF_FFFF), mk(0, 1, 0, 0, 20, 32'h20), 1'b0, 1'b1);
    vt[9] = mkv(mk(0, 1, 0, 0, 0, 32'hFFFF_FFFF), mk(1, 0, 0, 20, 0, 0), 1'b1, 1'b1);

    // Power-up reset; requests held during INIT must not be granted.
    reset_and_init(mk(1, 0, 1, 2, 0, 0), mk(0, 1, 0, 0, 3, 32'h3));

    for (int i = 0; i < 10; i++) begin
      step(vt[i].r0, vt[i].r1, g0, g1);
      check_bit("tbl_m0_gnt", obs_g0, vt[i].eg0);
      check_bit("tbl_m1_gnt", obs_g1, vt[i].eg1);
    end
    step(idle, idle, g0, g1);

    // Write then read on the next cycle through the RAM.
    step(mk(0, 1, 0, 0, 5, 32'hDEAD_BEEF), idle, g0, g1);
    step(idle, mk(1, 0, 5, 0, 0, 0), g0, g1);
    step(idle, idle, g0, g1);
    check_bit("wr_rd_rvalid1", obs_rv1, 1'b1);
    check_word("wr_rd_rdata_a", obs_a, 32'hDEAD_BEEF);
    check_word("wr_rd_rdata_b", obs_b, 32'h0);

    // Same-cycle write by M1 forwarded to M0's read.
    step(mk(1, 0, 7, 7, 0, 0), mk(0, 1, 0, 0, 7, 32'h1234_5678), g0, g1);
    check_bit("fwd_m0_gnt", obs_g0, 1'b1);
    check_bit("fwd_m1_gnt", obs_g1, 1'b1);
    step(idle, idle, g0, g1);
    check_bit("fwd_rvalid0", obs_rv0, 1'b1);
    check_word("fwd_rdata_a", obs_a, 32'h1234_5678);
    check_word("fwd_rdata_b", obs_b, 32'h1234_5678);

    // Both requesters read continuously: grants alternate.
    rd0 = mk(1, 0, 5, 7, 0, 0);
    rd1 = mk(1, 0, 7, 5, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(rd0, rd1, g0, g1);
      ga[k] = obs_g0;
      check_bit("alt_one_grant", obs_g0 ^ obs_g1, 1'b1);
      if (k > 0) begin
        check_bit("alt_toggle", obs_g0, ~ga[k-1]);
        check_bit("alt_rvalid0", obs_rv0, ga[k-1]);
      end
    end
    step(idle, idle, g0, g1);

    // Write-port conflict with p = 0: M0 (re+we) wins, M1 (we) waits one cycle.
    if (ref_p) step(idle, mk(0, 0, 0, 0, 0, 0), g0, g1);
    wrm1 = mk(0, 1, 0, 0, 31, 32'h31);
    step(mk(1, 1, 3, 4, 30, 32'h30), wrm1, g0, g1);
    check_bit("conf_m0_gnt", obs_g0, 1'b1);
    check_bit("conf_m1_gnt", obs_g1, 1'b0);
    step(idle, wrm1, g0, g1);
    check_bit("conf_m1_gnt_next", obs_g1, 1'b1);
    step(idle, idle, g0, g1);

    // Randomized traffic; a denied requester holds its request.
    pend0 = 1'b0;
    pend1 = 1'b0;
    cur0  = '0;
    cur1  = '0;
    for (int k = 0; k < 400; k++) begin
      if (!pend0) cur0 = rnd_req();
      if (!pend1) cur1 = rnd_req();
      step(cur0, cur1, g0, g1);
      pend0 = cur0.req && !g0;
      pend1 = cur1.req && !g1;
    end
    step(idle, idle, g0, g1);

    // Reset while reads are granted: no rvalid follows, sweep restarts at 1.
    step(mk(1, 0, 5, 7, 0, 0), mk(1, 0, 7, 5, 0, 0), g0, g1);
    reset_and_init(mk(1, 0, 5, 7, 0, 0), mk(1, 0, 7, 5, 0, 0));

    // Post-reset traffic confirms the RAM reads back cleared.
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!pend0) cur0 = rnd_req();
      if (!pend1) cur1 = rnd_req();
      step(cur0, cur1, g0, g1);
      pend0 = cur0.req && !g0;
      pend1 = cur1.req && !g1;
    end
    step(idle, idle, g0, g1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
